// File: rtl/div_16x8_seq.sv
`default_nettype none
// ============================================================================
//  Module      : div_16x8_seq
//  Description : Sequential restoring divider, 16-bit unsigned dividend by
//                8-bit unsigned divisor, giving an 8-bit quotient and an 8-bit
//                remainder. Valid/ready handshake on both sides, one quotient
//                bit per RUN cycle. Divide-by-zero and quotient overflow are
//                detected at the accept edge and answered without iterating.
//  Options     : APPROX_DIV_TRUNC_EN - when defined, only 8-TRUNC iterations
//                run; the low TRUNC quotient bits are forced to zero and the
//                remainder is that of floor(A/2^TRUNC) by B.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_16x8_seq #(
    parameter int TRUNC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] A,
    input  logic [7:0]  B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  Q,
    output logic [7:0]  REM,
    output logic        div_err
);

    // Number of RUN iterations per operation.
`ifdef APPROX_DIV_TRUNC_EN
    localparam logic [3:0] c_ITERS = 4'(8 - TRUNC);
`else
    localparam logic [3:0] c_ITERS = 4'd8;
`endif

    // TRUNC is only meaningful in 1..6; reject anything else at elaboration.
    generate
        if (TRUNC < 1 || TRUNC > 6) begin : g_trunc_range
            $error("div_16x8_seq: TRUNC must be in 1..6");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [7:0]  r_b;        // latched divisor
    logic [7:0]  r_a_lo;     // remaining dividend bits, MSB is the next one
    logic [7:0]  r_p;        // partial remainder; always < divisor, so 8 bits
    logic [7:0]  r_quo;      // quotient bits collected so far
    logic [3:0]  r_cnt;      // iterations completed
    logic [7:0]  r_q;
    logic [7:0]  r_rem;
    logic        r_err;

    logic        w_accept;
    logic        w_op_err;
    logic        w_last;
    logic [8:0]  w_p_shift;
    logic        w_ge;
    logic [7:0]  w_p_sub;
    logic [7:0]  w_p_next;
    logic [7:0]  w_quo_next;
    logic [7:0]  w_q_final;

    assign w_accept   = in_valid && (r_state == S_IDLE);
    // B==0 is also caught by the compare, but is kept explicit for clarity.
    assign w_op_err   = (B == 8'd0) || (A[15:8] >= B);
    assign w_last     = (r_cnt == (c_ITERS - 4'd1));

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign w_p_shift  = {r_p, r_a_lo[7]};
    assign w_ge       = (w_p_shift >= {1'b0, r_b});
    // The difference is below B whenever it is taken, so modulo-256 is exact.
    assign w_p_sub    = w_p_shift[7:0] - r_b;
    assign w_p_next   = w_ge ? w_p_sub : w_p_shift[7:0];
    assign w_quo_next = {r_quo[6:0], w_ge};

`ifdef APPROX_DIV_TRUNC_EN
    // Skipped iterations leave zeros in the low quotient bits.
    assign w_q_final  = w_quo_next << TRUNC;
`else
    assign w_q_final  = w_quo_next;
`endif

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = (r_state == S_DONE);
    assign Q          = r_q;
    assign REM        = r_rem;
    assign div_err    = r_err;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic for the IDLE/RUN/DONE handshake sequence.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_next = w_op_err ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, restoring iterations and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_b    <= 8'd0;
            r_a_lo <= 8'd0;
            r_p    <= 8'd0;
            r_quo  <= 8'd0;
            r_cnt  <= 4'd0;
            r_q    <= 8'd0;
            r_rem  <= 8'd0;
            r_err  <= 1'b0;
        end else if (w_accept) begin
            r_b    <= B;
            r_a_lo <= A[7:0];
            r_p    <= A[15:8];
            r_quo  <= 8'd0;
            r_cnt  <= 4'd0;
            if (w_op_err) begin
                r_q   <= 8'hFF;
                r_rem <= A[7:0];
                r_err <= 1'b1;
            end
        end else if (r_state == S_RUN) begin
            r_p    <= w_p_next;
            r_a_lo <= {r_a_lo[6:0], 1'b0};
            r_quo  <= w_quo_next;
            r_cnt  <= r_cnt + 4'd1;
            if (w_last) begin
                r_q   <= w_q_final;
                r_rem <= w_p_next;
                r_err <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_16x8_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_16x8_seq
//  Description : Self-checking bench for div_16x8_seq: reset state, exact and
//                error results, latency, backpressure, mid-run reset and a
//                modelled operand sweep. Expectations follow the
//                APPROX_DIV_TRUNC_EN setting of the build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_16x8_seq;

    localparam int c_TRUNC = 2;

`ifdef APPROX_DIV_TRUNC_EN
    localparam int         c_LAT      = 8 - c_TRUNC;
    localparam logic [7:0] c_Q_1000_7 = 8'd140;
    localparam logic [7:0] c_R_1000_7 = 8'd5;
    localparam logic [7:0] c_Q_FE01   = 8'hFC;   // floor(16256/255)=63, <<2
    localparam logic [7:0] c_R_FE01   = 8'hBF;   // 16256 mod 255 = 191
    localparam logic [7:0] c_Q_00FF_1 = 8'hFC;   // 63 << 2
`else
    localparam int         c_LAT      = 8;
    localparam logic [7:0] c_Q_1000_7 = 8'd142;
    localparam logic [7:0] c_R_1000_7 = 8'd6;
    localparam logic [7:0] c_Q_FE01   = 8'hFF;
    localparam logic [7:0] c_R_FE01   = 8'h00;
    localparam logic [7:0] c_Q_00FF_1 = 8'hFF;
`endif
    // Error results reach DONE on the accept edge itself, so out_valid is
    // already high in the cycle that follows it: zero further edges.
    localparam int c_ERR_LAT = 0;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A_in;
    logic [7:0]  B_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  Q;
    logic [7:0]  REM;
    logic        div_err;

    int n_checks = 0;
    int n_fail   = 0;

    div_16x8_seq #(.TRUNC(c_TRUNC)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A_in),
        .B         (B_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (Q),
        .REM       (REM),
        .div_err   (div_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One full transaction: accept, wait for the result, optional
    // backpressure with a stray in_valid, then drain.
    task automatic do_op(input string tag, input logic [15:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er, input logic eerr,
                         input int elat, input int hold);
        int guard;
        int lat;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        A_in     = a;
        B_in     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        A_in     = 16'($urandom);
        B_in     = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'(elat));
        check_eq({tag, "_Q"}, 32'(Q), 32'(eq));
        check_eq({tag, "_REM"}, 32'(REM), 32'(er));
        check_eq({tag, "_err"}, 32'(div_err), 32'(eerr));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            A_in     = 16'($urandom);
            B_in     = 8'($urandom_range(255, 1));
            tick();
            check_eq({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check_eq({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            check_eq({tag, "_hold_Q"}, 32'(Q), 32'(eq));
            check_eq({tag, "_hold_REM"}, 32'(REM), 32'(er));
            check_eq({tag, "_hold_err"}, 32'(div_err), 32'(eerr));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_drain_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    // Reference quotient/remainder for the modelled sweep.
    task automatic model(input logic [15:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r, output logic e);
        int ai;
        if (b == 8'd0 || a[15:8] >= b) begin
            q = 8'hFF;
            r = a[7:0];
            e = 1'b1;
        end else begin
`ifdef APPROX_DIV_TRUNC_EN
            ai = int'(a) >> c_TRUNC;
            q  = 8'((ai / int'(b)) << c_TRUNC);
`else
            ai = int'(a);
            q  = 8'(ai / int'(b));
`endif
            r  = 8'(ai % int'(b));
            e  = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] ra;
        logic [7:0]  rb;
        logic [7:0]  mq;
        logic [7:0]  mr;
        logic        me;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A_in      = 16'd0;
        B_in      = 8'd0;
        tick();
        tick();
        rst = 1'b0;

        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_Q", 32'(Q), 32'd0);
        check_eq("rst_REM", 32'(REM), 32'd0);
        check_eq("rst_err", 32'(div_err), 32'd0);

        do_op("div_1000_7", 16'd1000, 8'd7, c_Q_1000_7, c_R_1000_7, 1'b0, c_LAT, 0);
        do_op("div_max",    16'hFE01, 8'hFF, c_Q_FE01, c_R_FE01, 1'b0, c_LAT, 0);
        do_op("div_by_zero", 16'h1234, 8'h00, 8'hFF, 8'h34, 1'b1, c_ERR_LAT, 0);
        do_op("overflow",   16'hFFFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, c_ERR_LAT, 0);
        do_op("ovf_edge",   16'h0100, 8'h01, 8'hFF, 8'h00, 1'b1, c_ERR_LAT, 0);
        do_op("zero_by_1",  16'h0000, 8'h01, 8'h00, 8'h00, 1'b0, c_LAT, 0);
        do_op("ff_by_1",    16'h00FF, 8'h01, c_Q_00FF_1, 8'h00, 1'b0, c_LAT, 0);
        do_op("backpress",  16'd1000, 8'd7, c_Q_1000_7, c_R_1000_7, 1'b0, c_LAT, 5);

        // The stray in_valid during backpressure must not have been queued.
        tick();
        tick();
        check_eq("no_queue_valid", 32'(out_valid), 32'd0);
        check_eq("no_queue_in_ready", 32'(in_ready), 32'd1);

        // Reset asserted on the 4th RUN edge discards the operation.
        A_in     = 16'd1000;
        B_in     = 8'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
        check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_Q", 32'(Q), 32'd0);
        check_eq("midrst_REM", 32'(REM), 32'd0);
        check_eq("midrst_err", 32'(div_err), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        check_eq("midrst_discarded", 32'(out_valid), 32'd0);
        do_op("after_rst", 16'd1000, 8'd7, c_Q_1000_7, c_R_1000_7, 1'b0, c_LAT, 0);

        // Modelled sweep, mostly legal operands with some raw random pairs.
        for (int i = 0; i < 300; i++) begin
            rb = 8'($urandom_range(255, 1));
            if (i % 8 == 0) begin
                ra = 16'($urandom);
                rb = 8'($urandom);
            end else begin
                ra = {8'($urandom_range(int'(rb) - 1, 0)), 8'($urandom)};
            end
            model(ra, rb, mq, mr, me);
            do_op("sweep", ra, rb, mq, mr, me, me ? c_ERR_LAT : c_LAT, i % 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
